// File: rtl/aes_inverse_iterative_core_if.sv
`default_nettype none
// ==========================================================================
// Module   : aes_inverse_iterative_core_if
// Purpose  : key-load port plus valid/ready ciphertext-in / plaintext-out
// Revision : 1.0
// ==========================================================================
interface aes_inverse_iterative_core_if;
  logic         keyWrite;
  logic [3:0]   keyIndex;
  logic [127:0] keyData;
  logic         keyReady;
  logic         inValid;
  logic         inReady;
  logic [127:0] inData;
  logic         outValid;
  logic         outReady;
  logic [127:0] outData;

  // master: the block feeding keys/ciphertext and draining plaintext
  modport master (
    output keyWrite, keyIndex, keyData, inValid, inData, outReady,
    input  keyReady, inReady, outValid, outData
  );

  modport slave (
    input  keyWrite, keyIndex, keyData, inValid, inData, outReady,
    output keyReady, inReady, outValid, outData
  );
endinterface
`default_nettype wire

// File: rtl/aes_inverse_iterative_core.sv
`default_nettype none
// ==========================================================================
// Module   : aes_inverse_iterative_core
// Purpose  : iterative AES-128 inverse cipher, one shared inverse round,
//            internal round-key buffer. Option macro: AES_DEC_BACK_TO_BACK_EN
// Revision : 1.0
// ==========================================================================
module aes_inverse_iterative_core #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  aes_inverse_iterative_core_if.slave bus
);

  localparam logic [3:0] c_last_idx    = 4'(NUM_ROUNDS);
  localparam logic [3:0] c_first_round = 4'(NUM_ROUNDS - 1);

  // Inverse S-box, entry 0 in the most significant byte
  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } fsm_t;

  fsm_t                r_fsm;
  logic [127:0]        r_state;
  logic [3:0]          r_round;
  logic [NUM_ROUNDS:0] r_key_mask;
  logic [127:0]        r_keys [0:NUM_ROUNDS];
  logic                r_out_valid;
  logic [127:0]        r_out_data;

  logic         w_key_ready;
  logic         w_mask_full;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_key_we;
  logic [127:0] w_sub;
  logic [127:0] w_round_out;
  logic [127:0] w_final_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = c_inv_sbox[2047 - 8*int'(s[127-8*i -: 8]) -: 8];
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Shared datapath: the round and final steps differ only in key and mix stage
  assign w_sub       = inv_sub_bytes(inv_shift_rows(r_state));
  assign w_round_out = inv_mix_columns(w_sub ^ r_keys[r_round]);
  assign w_final_out = w_sub ^ r_keys[0];

  assign w_key_ready = (r_fsm == S_IDLE);
  assign w_mask_full = &r_key_mask;
`ifdef AES_DEC_BACK_TO_BACK_EN
  assign w_in_ready  = w_mask_full &&
                       ((r_fsm == S_IDLE) || ((r_fsm == S_DONE) && bus.outReady));
`else
  assign w_in_ready  = w_mask_full && (r_fsm == S_IDLE);
`endif
  assign w_accept    = bus.inValid && w_in_ready;
  assign w_key_we    = bus.keyWrite && w_key_ready && (bus.keyIndex <= c_last_idx);

  assign bus.keyReady = w_key_ready;
  assign bus.inReady  = w_in_ready;
  assign bus.outValid = r_out_valid;
  assign bus.outData  = r_out_data;

  // Key contents need no reset; only the mask gates use of the buffer
  always_ff @(posedge clock) begin
    if (w_key_we) begin
      r_keys[bus.keyIndex] <= bus.keyData;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_round     <= '0;
      r_key_mask  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_key_we) begin
        r_key_mask[bus.keyIndex] <= 1'b1;
      end
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= bus.inData ^ r_keys[NUM_ROUNDS];
            r_round <= c_first_round;
            r_fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= w_round_out;
          r_round <= r_round - 4'd1;
          if (r_round == 4'd1) begin
            r_fsm <= S_FINAL;
          end
        end
        S_FINAL: begin
          r_state     <= w_final_out;
          r_out_data  <= w_final_out;
          r_out_valid <= 1'b1;
          r_fsm       <= S_DONE;
        end
        S_DONE: begin
          if (bus.outReady) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_state <= bus.inData ^ r_keys[NUM_ROUNDS];
              r_round <= c_first_round;
              r_fsm   <= S_ROUND;
            end else begin
              r_fsm <= S_IDLE;
            end
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
